// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: expands one register operation at a time into the
// read/write cycles of a 32 x 8 register file (combinational read,
// falling-edge write). All port signals come straight from flops.
module reg_op_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_WRI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B,
    ST_CLR
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] rb_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] tmp;
  // pend marks the wrap-up cycle in IDLE before done/result are published
  logic              pend;
  logic              fin_upd;
  logic [DATA_W-1:0] fin_res;
  logic              fin_carry;

  // Sequencer FSM with registered port, handshake and completion outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend      <= 1'b0;
      cmd_ready <= 1'b1;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      rf_we     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend) begin
            pend      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            carry     <= fin_carry;
            if (fin_upd) result <= fin_res;
          end else if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            cmd_ready <= 1'b0;
            fin_upd   <= 1'b1;
            fin_carry <= 1'b0;
            fin_res   <= '0;
            case (cmd_op)
              OP_WRI: begin
                state    <= ST_WR_A;
                rf_addr  <= cmd_ra;
                rf_wdata <= cmd_imm;
                rf_we    <= 1'b1;
              end
              OP_MOV: begin
                state   <= ST_RD_A;
                rf_addr <= cmd_rb;
              end
              OP_SWAP, OP_INC, OP_DEC, OP_RD: begin
                state   <= ST_RD_A;
                rf_addr <= cmd_ra;
              end
              OP_CLR: begin
                if (cmd_ra <= cmd_rb) begin
                  state    <= ST_CLR;
                  idx      <= cmd_ra;
                  rf_addr  <= cmd_ra;
                  rf_wdata <= '0;
                  rf_we    <= 1'b1;
                end else begin
                  pend <= 1'b1;
                end
              end
              default: begin
                pend    <= 1'b1;
                fin_upd <= 1'b0;
              end
            endcase
          end
        end

        ST_RD_A: begin
          case (op_q)
            OP_MOV: begin
              state    <= ST_WR_A;
              rf_addr  <= ra_q;
              rf_wdata <= rf_rdata;
              rf_we    <= 1'b1;
            end
            OP_SWAP: begin
              state   <= ST_RD_B;
              tmp     <= rf_rdata;
              rf_addr <= rb_q;
            end
            OP_INC: begin
              state    <= ST_WR_A;
              rf_addr  <= ra_q;
              rf_wdata <= rf_rdata + DATA_W'(1);
              rf_we    <= 1'b1;
            end
            OP_DEC: begin
              state    <= ST_WR_A;
              rf_addr  <= ra_q;
              rf_wdata <= rf_rdata - DATA_W'(1);
              rf_we    <= 1'b1;
            end
            default: begin
              state    <= ST_IDLE;
              pend     <= 1'b1;
              fin_res  <= rf_rdata;
              rf_addr  <= '0;
              rf_wdata <= '0;
              rf_we    <= 1'b0;
            end
          endcase
        end

        // Second SWAP read: old rb goes straight out as the write to ra
        ST_RD_B: begin
          state    <= ST_WR_A;
          rf_addr  <= ra_q;
          rf_wdata <= rf_rdata;
          rf_we    <= 1'b1;
        end

        ST_WR_A: begin
          if (op_q == OP_SWAP) begin
            state    <= ST_WR_B;
            rf_addr  <= rb_q;
            rf_wdata <= tmp;
          end else begin
            state     <= ST_IDLE;
            pend      <= 1'b1;
            fin_res   <= rf_wdata;
            fin_carry <= ((op_q == OP_INC) && (rf_wdata == '0)) ||
                         ((op_q == OP_DEC) && (rf_wdata == '1));
            rf_addr   <= '0;
            rf_wdata  <= '0;
            rf_we     <= 1'b0;
          end
        end

        ST_WR_B: begin
          state    <= ST_IDLE;
          pend     <= 1'b1;
          fin_res  <= tmp;
          rf_addr  <= '0;
          rf_wdata <= '0;
          rf_we    <= 1'b0;
        end

        // idx never exceeds rb_q, so reaching r31 ends without wrapping
        ST_CLR: begin
          if (idx == rb_q) begin
            state    <= ST_IDLE;
            pend     <= 1'b1;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rf_we    <= 1'b0;
          end else begin
            idx     <= idx + ADDR_W'(1);
            rf_addr <= idx + ADDR_W'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          rf_addr  <= '0;
          rf_wdata <= '0;
          rf_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: register file environment, high-level
// operation model, directed scenarios and randomized operation stream.
module tb_reg_op_sequencer;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_WRI  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_DEC  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RD   = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [4:0] cmd_ra;
  logic [4:0] cmd_rb;
  logic [7:0] cmd_imm;
  logic [4:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_we;
  logic [7:0] rf_rdata;
  logic       done;
  logic [7:0] result;
  logic       carry;

  int checks = 0;
  int errors = 0;

  // Register file environment and write monitor
  logic [7:0]  rf [32];
  logic [12:0] wq [$];
  assign rf_rdata = rf[rf_addr];

  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      rf[rf_addr] = rf_wdata;
      wq.push_back({rf_addr, rf_wdata});
    end
  end

  // Reference model state
  logic [7:0]  mem [32];
  logic [12:0] ew [$];
  logic [7:0]  last_res;
  int          exp_lat;
  logic [7:0]  exp_res;
  logic        exp_car;

  // Observations from the last operation
  logic [5:0]  aq [$];
  int          obs_lat;
  logic [7:0]  obs_res;
  logic        obs_car;
  bit          obs_rdy_ok;
  logic        obs_rdy_done;

  reg_op_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm   (cmd_imm),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_we     (rf_we),
    .rf_rdata  (rf_rdata),
    .done      (done),
    .result    (result),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Expected effect of one operation: register updates, write list, latency
  task automatic ref_op(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [7:0] imm);
    logic [7:0] a;
    logic [7:0] b;
    ew.delete();
    exp_car = 1'b0;
    exp_res = last_res;
    case (op)
      OP_NOP: exp_lat = 1;
      OP_WRI: begin
        mem[ra] = imm; ew.push_back({ra, imm}); exp_res = imm; exp_lat = 2;
      end
      OP_MOV: begin
        a = mem[rb]; mem[ra] = a; ew.push_back({ra, a}); exp_res = a; exp_lat = 3;
      end
      OP_SWAP: begin
        a = mem[ra]; b = mem[rb];
        mem[ra] = b; mem[rb] = a;
        ew.push_back({ra, b}); ew.push_back({rb, a});
        exp_res = a; exp_lat = 5;
      end
      OP_INC: begin
        a = 8'((int'(mem[ra]) + 1) % 256);
        exp_car = (mem[ra] == 8'd255);
        mem[ra] = a; ew.push_back({ra, a}); exp_res = a; exp_lat = 3;
      end
      OP_DEC: begin
        a = 8'((int'(mem[ra]) + 255) % 256);
        exp_car = (mem[ra] == 8'd0);
        mem[ra] = a; ew.push_back({ra, a}); exp_res = a; exp_lat = 3;
      end
      OP_CLR: begin
        exp_res = 8'd0;
        exp_lat = 1;
        for (int i = int'(ra); i <= int'(rb); i++) begin
          mem[i] = 8'd0;
          ew.push_back({5'(i), 8'd0});
          exp_lat++;
        end
      end
      default: begin
        exp_res = mem[ra]; exp_lat = 2;
      end
    endcase
    last_res = exp_res;
  endtask

  // Offer one command and follow it to its done pulse (bounded wait)
  task automatic do_op(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [7:0] imm);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_valid = 1'b1;
    wq.delete();
    aq.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_ra = 5'($urandom); cmd_rb = 5'($urandom);
    cmd_imm = 8'($urandom);
    obs_lat = 0;
    obs_rdy_ok = 1'b1;
    while (done !== 1'b1) begin
      if (cmd_ready !== 1'b0) obs_rdy_ok = 1'b0;
      aq.push_back({rf_we, rf_addr});
      if (obs_lat >= 300) break;
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_res = result;
    obs_car = carry;
    obs_rdy_done = cmd_ready;
  endtask

  function automatic bit writes_match();
    if (wq.size() != ew.size()) return 1'b0;
    foreach (wq[i]) if (wq[i] !== ew[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int rf_diffs();
    int n = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== mem[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || result !== 8'd0 || carry !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got we=%b done=%b result=%h carry=%b exp 0/0/00/0",
                 c, rf_we, done, result, carry);
      end
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b we=%b done=%b exp 1/0/0", cmd_ready, rf_we, done);
    end
    checks++;
    if (rf[0] !== mem[0]) begin
      errors++;
      $display("FAIL reset_no_accept got r0=%h exp %h", rf[0], mem[0]);
    end
    last_res = 8'd0;
  endtask

  task automatic test_wri_rd();
    ref_op(OP_WRI, 5'd3, 5'd0, 8'h5a);
    do_op(OP_WRI, 5'd3, 5'd0, 8'h5a);
    checks++;
    if (obs_lat !== 2 || obs_res !== 8'h5a || obs_car !== 1'b0) begin
      errors++;
      $display("FAIL wri got lat=%0d res=%h car=%b exp lat=2 res=5a car=0", obs_lat, obs_res, obs_car);
    end
    checks++;
    if (!writes_match() || aq.size() < 1 || aq[0] !== 6'h23) begin
      errors++;
      $display("FAIL wri_port got %0d writes exp 1 write of 5a to r3", wq.size());
    end
    checks++;
    if (!obs_rdy_ok || obs_rdy_done !== 1'b1) begin
      errors++;
      $display("FAIL wri_ready got busy_ok=%b done_ready=%b exp 1/1", obs_rdy_ok, obs_rdy_done);
    end
    ref_op(OP_RD, 5'd3, 5'd0, 8'h00);
    do_op(OP_RD, 5'd3, 5'd0, 8'h00);
    checks++;
    if (obs_lat !== 2 || obs_res !== 8'h5a || wq.size() != 0) begin
      errors++;
      $display("FAIL rd got lat=%0d res=%h writes=%0d exp lat=2 res=5a writes=0",
               obs_lat, obs_res, wq.size());
    end
  endtask

  task automatic test_swap();
    logic [5:0] ea [$];
    ref_op(OP_WRI, 5'd1, 5'd0, 8'h11); do_op(OP_WRI, 5'd1, 5'd0, 8'h11);
    ref_op(OP_WRI, 5'd2, 5'd0, 8'h22); do_op(OP_WRI, 5'd2, 5'd0, 8'h22);
    ref_op(OP_SWAP, 5'd1, 5'd2, 8'h00);
    do_op(OP_SWAP, 5'd1, 5'd2, 8'h00);
    ea = '{6'h01, 6'h02, 6'h21, 6'h22, 6'h00};
    checks++;
    if (obs_lat !== 5 || obs_res !== 8'h11 || !writes_match()) begin
      errors++;
      $display("FAIL swap got lat=%0d res=%h writes=%0d exp lat=5 res=11 writes=2",
               obs_lat, obs_res, wq.size());
    end
    checks++;
    if (aq.size() != 5 || aq[0] !== ea[0] || aq[1] !== ea[1] || aq[2] !== ea[2] ||
        aq[3] !== ea[3] || aq[4] !== ea[4]) begin
      errors++;
      $display("FAIL swap_port_seq got %0d cycles first=%h exp 5 cycles 01,02,21,22,00",
               aq.size(), aq.size() > 0 ? aq[0] : 6'h3f);
    end
    checks++;
    if (!obs_rdy_ok || obs_rdy_done !== 1'b1 || rf[1] !== 8'h22 || rf[2] !== 8'h11) begin
      errors++;
      $display("FAIL swap_regs got r1=%h r2=%h busy_ok=%b exp r1=22 r2=11 busy_ok=1",
               rf[1], rf[2], obs_rdy_ok);
    end
  endtask

  task automatic test_incdec();
    ref_op(OP_DEC, 5'd29, 5'd0, 8'h00);
    do_op(OP_DEC, 5'd29, 5'd0, 8'h00);
    checks++;
    if (obs_lat !== 3 || obs_res !== 8'hfe || obs_car !== 1'b0 || rf[29] !== 8'hfe) begin
      errors++;
      $display("FAIL dec_sp got lat=%0d res=%h car=%b r29=%h exp 3/fe/0/fe",
               obs_lat, obs_res, obs_car, rf[29]);
    end
    ref_op(OP_WRI, 5'd4, 5'd0, 8'hff); do_op(OP_WRI, 5'd4, 5'd0, 8'hff);
    ref_op(OP_INC, 5'd4, 5'd0, 8'h00);
    do_op(OP_INC, 5'd4, 5'd0, 8'h00);
    checks++;
    if (obs_res !== 8'h00 || obs_car !== 1'b1 || rf[4] !== 8'h00 || !writes_match()) begin
      errors++;
      $display("FAIL inc_wrap got res=%h car=%b r4=%h exp 00/1/00", obs_res, obs_car, rf[4]);
    end
    ref_op(OP_WRI, 5'd0, 5'd0, 8'h3c);
    do_op(OP_WRI, 5'd0, 5'd0, 8'h3c);
    checks++;
    if (obs_car !== 1'b0 || obs_res !== 8'h3c) begin
      errors++;
      $display("FAIL carry_clear got car=%b res=%h exp 0/3c", obs_car, obs_res);
    end
  endtask

  task automatic test_clr();
    for (int i = 5; i <= 9; i++) begin
      ref_op(OP_WRI, 5'(i), 5'd0, 8'(8'h40 + i));
      do_op(OP_WRI, 5'(i), 5'd0, 8'(8'h40 + i));
    end
    ref_op(OP_CLR, 5'd5, 5'd8, 8'h00);
    do_op(OP_CLR, 5'd5, 5'd8, 8'h00);
    checks++;
    if (obs_lat !== 5 || obs_res !== 8'h00 || !writes_match() || rf[9] !== 8'h49) begin
      errors++;
      $display("FAIL clr_5_8 got lat=%0d writes=%0d r9=%h exp lat=5 writes=4 r9=49",
               obs_lat, wq.size(), rf[9]);
    end
    ref_op(OP_CLR, 5'd8, 5'd5, 8'h00);
    do_op(OP_CLR, 5'd8, 5'd5, 8'h00);
    checks++;
    if (obs_lat !== 1 || wq.size() != 0 || obs_res !== 8'h00) begin
      errors++;
      $display("FAIL clr_empty got lat=%0d writes=%0d res=%h exp 1/0/00", obs_lat, wq.size(), obs_res);
    end
    ref_op(OP_CLR, 5'd30, 5'd31, 8'h00);
    do_op(OP_CLR, 5'd30, 5'd31, 8'h00);
    checks++;
    if (obs_lat !== 3 || !writes_match() || obs_rdy_done !== 1'b1) begin
      errors++;
      $display("FAIL clr_top got lat=%0d writes=%0d ready=%b exp 3/2/1", obs_lat, wq.size(), obs_rdy_done);
    end
    ref_op(OP_WRI, 5'd10, 5'd0, 8'h99); do_op(OP_WRI, 5'd10, 5'd0, 8'h99);
    ref_op(OP_NOP, 5'd0, 5'd0, 8'h00);
    do_op(OP_NOP, 5'd0, 5'd0, 8'h00);
    checks++;
    if (obs_lat !== 1 || obs_res !== 8'h99 || wq.size() != 0 || obs_rdy_done !== 1'b1) begin
      errors++;
      $display("FAIL nop got lat=%0d res=%h writes=%0d exp 1/99/0", obs_lat, obs_res, wq.size());
    end
    checks++;
    if (rf_diffs() != 0) begin
      errors++;
      $display("FAIL clr_regs got %0d differing registers exp 0", rf_diffs());
    end
  endtask

  task automatic test_reset_mid_swap();
    int pulses;
    ref_op(OP_WRI, 5'd1, 5'd0, 8'h11); do_op(OP_WRI, 5'd1, 5'd0, 8'h11);
    ref_op(OP_WRI, 5'd2, 5'd0, 8'h22); do_op(OP_WRI, 5'd2, 5'd0, 8'h22);
    cmd_op = OP_SWAP; cmd_ra = 5'd1; cmd_rb = 5'd2; cmd_valid = 1'b1;
    wq.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midswap_abort got we=%b done=%b exp 0/0", rf_we, done);
    end
    rst_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midswap_ready got %b exp 1", cmd_ready);
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || rf_we === 1'b1) pulses++;
    end
    mem[1] = 8'h22;
    last_res = 8'h00;
    checks++;
    if (pulses != 0 || rf[1] !== 8'h22 || rf[2] !== 8'h22 || wq.size() != 1 || result !== 8'h00) begin
      errors++;
      $display("FAIL midswap_state got activity=%0d r1=%h r2=%h writes=%0d res=%h exp 0/22/22/1/00",
               pulses, rf[1], rf[2], wq.size(), result);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [7:0] imm;
    int bad;
    for (int n = 0; n < 80; n++) begin
      op  = 3'($urandom);
      ra  = 5'($urandom);
      rb  = 5'($urandom);
      imm = 8'($urandom);
      if (op == OP_CLR && $urandom_range(0, 1) == 0) rb = 5'($urandom_range(int'(ra), 31));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      ref_op(op, ra, rb, imm);
      do_op(op, ra, rb, imm);
      checks++;
      if (obs_lat !== exp_lat || obs_res !== exp_res || obs_car !== exp_car) begin
        errors++;
        $display("FAIL rand%0d op=%0d ra=%0d rb=%0d got lat=%0d res=%h car=%b exp lat=%0d res=%h car=%b",
                 n, op, ra, rb, obs_lat, obs_res, obs_car, exp_lat, exp_res, exp_car);
      end
      checks++;
      if (!writes_match() || !obs_rdy_ok || obs_rdy_done !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_port op=%0d got writes=%0d busy_ok=%b ready=%b exp writes=%0d 1/1",
                 n, op, wq.size(), obs_rdy_ok, obs_rdy_done, ew.size());
      end
    end
    bad = rf_diffs();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_regs got %0d differing registers exp 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 8'($urandom);
      mem[i] = rf[i];
    end
    rf[29] = 8'hff;
    mem[29] = 8'hff;
    last_res = 8'h00;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = OP_WRI;
    cmd_ra = 5'd0;
    cmd_rb = 5'd0;
    cmd_imm = 8'h77;
    test_reset();
    test_wri_rd();
    test_swap();
    test_incdec();
    test_clr();
    test_reset_mid_swap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
